// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that serialises one 32-bit word per grant onto a shared byte UART TX, MSB first.
// Optional UART_TX_HDR_EN: prefixes each word with header byte {4'hA, grant index}.
module uart_tx_word_arbiter #(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 32'd2000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  input  logic [32*N-1:0]  i_wdata,
  output logic [N-1:0]     o_ack,
  output logic             o_err,
  output logic [N-1:0]     o_grant,
  output logic             o_busy,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_en,
  input  logic             i_tx_done
);

  localparam int unsigned IW = 4;
  localparam int unsigned CW = 3;
`ifdef UART_TX_HDR_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(4);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(3);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_shreg, w_shreg_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]     r_wdog, w_wdog_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;
  logic [N-1:0]    r_ack, w_ack_nxt;
  logic            r_err, w_err_nxt;
  logic            r_busy, w_busy_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_tx_en, w_tx_en_nxt;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [31:0]     w_word;
  int unsigned     w_dist;
  int unsigned     w_best;

  // Round-robin pick: smallest distance past the last winner.
  always_comb begin : pick_p
    w_found = 1'b0;
    w_pick  = '0;
    w_best  = N;
    w_dist  = '0;
    w_word  = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_dist = (32'(i) + N - 32'd1 - 32'(r_last)) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_pick  = IW'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (IW'(i) == w_pick) w_word = i_wdata[32*i +: 32];
    end
  end

  always_comb begin : next_p
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_cnt_nxt     = r_cnt;
    w_wdog_nxt    = r_wdog;
    w_idx_nxt     = r_idx;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_ack_nxt     = '0;
    w_err_nxt     = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_tx_en_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = w_pick;
          w_grant_nxt = N'(1) << w_pick;
          w_shreg_nxt = w_word;
          w_cnt_nxt   = '0;
          w_tx_en_nxt = 1'b1;
`ifdef UART_TX_HDR_EN
          w_tx_data_nxt = {4'hA, w_pick};
`else
          w_tx_data_nxt = w_word[31:24];
`endif
        end
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT;
        w_wdog_nxt  = '0;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = ST_DONE;
            w_ack_nxt   = r_grant;
          end else begin
            w_state_nxt = ST_SEND;
            w_cnt_nxt   = r_cnt + CW'(1);
            w_tx_en_nxt = 1'b1;
`ifdef UART_TX_HDR_EN
            // Header just went out; first data byte is the unshifted MSB.
            if (r_cnt == '0) begin
              w_tx_data_nxt = r_shreg[31:24];
            end else begin
              w_shreg_nxt   = {r_shreg[23:0], 8'h00};
              w_tx_data_nxt = r_shreg[23:16];
            end
`else
            w_shreg_nxt   = {r_shreg[23:0], 8'h00};
            w_tx_data_nxt = r_shreg[23:16];
`endif
          end
        end else begin
          w_wdog_nxt = r_wdog + 32'd1;
          if ((TIMEOUT != 0) && (r_wdog == TIMEOUT - 32'd1)) begin
            w_state_nxt = ST_DONE;
            w_ack_nxt   = r_grant;
            w_err_nxt   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_last_nxt  = r_idx;
        w_grant_nxt = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin : reg_p
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_idx     <= '0;
      r_last    <= IW'(N - 1);
      r_grant   <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wdog    <= w_wdog_nxt;
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_en   <= w_tx_en_nxt;
    end
  end

  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_grant   = r_grant;
  assign o_busy    = r_busy;
  assign o_tx_data = r_tx_data;
  assign o_tx_en   = r_tx_en;

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Scoreboard bench for uart_tx_word_arbiter with a 10-cycle byte transmitter model.
module tb_uart_tx_word_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned TMO = 50;
`ifdef UART_TX_HDR_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] wdata = '0;
  logic [N-1:0]    ack, grant;
  logic            err, busy, tx_en, tx_done;
  logic [7:0]      tx_data;
  logic            model_done = 1'b0;
  logic            stray = 1'b0;
  logic            model_en = 1'b1;
  int              dly = 0;
  int              cyc = 0;
  int              vectors = 0;
  int              miscompares = 0;
  int              first_wait = 0;

  logic [7:0]   exp_bytes[$];
  logic [7:0]   obs_bytes[$];
  logic [N-1:0] exp_grant[$];
  logic [N-1:0] obs_grant[$];
  logic [N-1:0] exp_ack[$];
  logic [N-1:0] obs_ack[$];
  logic         obs_err[$];
  logic         obs_lat[$];

  uart_tx_word_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_wdata   (wdata),
    .o_ack     (ack),
    .o_err     (err),
    .o_grant   (grant),
    .o_busy    (busy),
    .o_tx_data (tx_data),
    .o_tx_en   (tx_en),
    .i_tx_done (tx_done)
  );

  always #5 clk = ~clk;

  assign tx_done = model_done | stray;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: TxDone some 10 cycles after each TxEn.
  always @(posedge clk) begin
    if (rst) begin
      dly        <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (tx_en && model_en) dly <= 10;
      else if (dly > 0) begin
        dly <= dly - 1;
        if (dly == 1) model_done <= 1'b1;
      end
    end
  end

  task automatic clear_queues();
    exp_bytes.delete(); obs_bytes.delete(); exp_grant.delete(); obs_grant.delete();
    exp_ack.delete(); obs_ack.delete(); obs_err.delete(); obs_lat.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    stray = 1'b0;
    model_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_queues();
  endtask

  task automatic push_word(input int idx, input logic [31:0] w);
    logic [N-1:0] g;
    g = N'(1) << idx;
`ifdef UART_TX_HDR_EN
    exp_bytes.push_back({4'hA, 4'(idx)});
    exp_grant.push_back(g);
`endif
    for (int b = 0; b < 4; b++) begin
      exp_bytes.push_back(w[31 - 8*b -: 8]);
      exp_grant.push_back(g);
    end
    exp_ack.push_back(g);
  endtask

  // Gathers one word's bytes and its Ack; ok=0 if any bounded wait expires.
  task automatic collect_word(input bit stray_send, output bit ok);
    bit tmo;
    logic prevd;
    ok = 1'b1;
    for (int b = 0; b < NB; b++) begin
      tmo = 1'b1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (tx_en) begin
          tmo = 1'b0;
          if (b == 0) first_wait = c;
          break;
        end
      end
      if (tmo) begin ok = 1'b0; return; end
      obs_bytes.push_back(tx_data);
      obs_grant.push_back(grant);
      if (stray_send) begin
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
      end
    end
    prevd = 1'b0;
    tmo = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ack != '0) begin tmo = 1'b0; break; end
      prevd = tx_done;
    end
    if (tmo) begin ok = 1'b0; return; end
    obs_ack.push_back(ack);
    obs_err.push_back(err);
    obs_lat.push_back(prevd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({grant, ack, err, busy, tx_en, tx_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got grant=%b ack=%b err=%b busy=%b txen=%b txdata=%h, want all zero",
               grant, ack, err, busy, tx_en, tx_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, tx_en, grant} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b txen=%b grant=%b, want 0", busy, tx_en, grant);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] e8, o8;
    logic [N-1:0] eg, og, ea, oa;
    logic oe, ol;
    do_reset();
    wdata[31:0] = 32'hDEADBEEF;
    push_word(0, 32'hDEADBEEF);
    req = 2'b01;
    collect_word(1'b0, ok);
    req = '0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_timeout: got stalled transfer, want complete word"); end
    vectors++;
    if (first_wait !== 0) begin miscompares++; $display("FAIL single_latency: got %0d extra cycles, want 0", first_wait); end
    while (exp_bytes.size() != 0) begin
      e8 = exp_bytes.pop_front(); eg = exp_grant.pop_front();
      o8 = (obs_bytes.size() != 0) ? obs_bytes.pop_front() : 8'hxx;
      og = (obs_grant.size() != 0) ? obs_grant.pop_front() : 'x;
      vectors++;
      if (o8 !== e8 || og !== eg) begin
        miscompares++;
        $display("FAIL single_byte: got %h grant %b, want %h grant %b", o8, og, e8, eg);
      end
    end
    while (exp_ack.size() != 0) begin
      ea = exp_ack.pop_front();
      oa = (obs_ack.size() != 0) ? obs_ack.pop_front() : 'x;
      oe = (obs_err.size() != 0) ? obs_err.pop_front() : 1'bx;
      ol = (obs_lat.size() != 0) ? obs_lat.pop_front() : 1'bx;
      vectors++;
      if (oa !== ea || oe !== 1'b0 || ol !== 1'b1) begin
        miscompares++;
        $display("FAIL single_ack: got ack=%b err=%b after_done=%b, want ack=%b err=0 after_done=1", oa, oe, ol, ea);
      end
    end
    @(negedge clk);
    vectors++;
    if (grant !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: got grant=%b busy=%b, want 0 0", grant, busy);
    end
  endtask

  task automatic test_contention();
    bit ok;
    bit all_ok;
    logic [7:0] e8, o8;
    logic [N-1:0] eg, og, ea, oa;
    logic oe, ol;
    do_reset();
    wdata = {32'h22222222, 32'h11111111};
    for (int w = 0; w < 6; w++) push_word(w % 2, (w % 2 == 0) ? 32'h11111111 : 32'h22222222);
    req = 2'b11;
    all_ok = 1'b1;
    for (int w = 0; w < 6; w++) begin
      collect_word(1'b0, ok);
      if (!ok) all_ok = 1'b0;
      if (w == 4) req[0] = 1'b0;
      if (w == 5) req[1] = 1'b0;
    end
    req = '0;
    vectors++;
    if (!all_ok) begin miscompares++; $display("FAIL contention_timeout: got stalled transfer, want 6 words"); end
    while (exp_bytes.size() != 0) begin
      e8 = exp_bytes.pop_front(); eg = exp_grant.pop_front();
      o8 = (obs_bytes.size() != 0) ? obs_bytes.pop_front() : 8'hxx;
      og = (obs_grant.size() != 0) ? obs_grant.pop_front() : 'x;
      vectors++;
      if (o8 !== e8 || og !== eg) begin
        miscompares++;
        $display("FAIL contention_byte: got %h grant %b, want %h grant %b", o8, og, e8, eg);
      end
    end
    while (exp_ack.size() != 0) begin
      ea = exp_ack.pop_front();
      oa = (obs_ack.size() != 0) ? obs_ack.pop_front() : 'x;
      oe = (obs_err.size() != 0) ? obs_err.pop_front() : 1'bx;
      ol = (obs_lat.size() != 0) ? obs_lat.pop_front() : 1'bx;
      vectors++;
      if (oa !== ea || oe !== 1'b0 || ol !== 1'b1) begin
        miscompares++;
        $display("FAIL contention_ack: got ack=%b err=%b after_done=%b, want ack=%b err=0 after_done=1", oa, oe, ol, ea);
      end
    end
  endtask

  task automatic test_stray_done();
    bit ok;
    logic [7:0] e8, o8;
    logic [N-1:0] eg, og, ea, oa;
    logic oe;
    do_reset();
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_idle: got busy=%b txen=%b, want 0 0", busy, tx_en);
    end
    wdata[31:0] = 32'hCAFEF00D;
    push_word(0, 32'hCAFEF00D);
    req = 2'b01;
    collect_word(1'b1, ok);
    req = '0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stray_timeout: got stalled transfer, want complete word"); end
    while (exp_bytes.size() != 0) begin
      e8 = exp_bytes.pop_front(); eg = exp_grant.pop_front();
      o8 = (obs_bytes.size() != 0) ? obs_bytes.pop_front() : 8'hxx;
      og = (obs_grant.size() != 0) ? obs_grant.pop_front() : 'x;
      vectors++;
      if (o8 !== e8 || og !== eg) begin
        miscompares++;
        $display("FAIL stray_byte: got %h grant %b, want %h grant %b", o8, og, e8, eg);
      end
    end
    ea = exp_ack.pop_front();
    oa = (obs_ack.size() != 0) ? obs_ack.pop_front() : 'x;
    oe = (obs_err.size() != 0) ? obs_err.pop_front() : 1'bx;
    vectors++;
    if (oa !== ea || oe !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_ack: got ack=%b err=%b, want ack=%b err=0", oa, oe, ea);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit tmo;
    int c_send, c_ack, extra;
    do_reset();
    model_en = 1'b0;
    wdata[31:0] = 32'h55AA55AA;
    req = 2'b01;
    c_send = 0;
    c_ack = 0;
    extra = 0;
    tmo = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_en) begin tmo = 1'b0; c_send = cyc; break; end
    end
    if (!tmo) begin
      tmo = 1'b1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (tx_en) extra++;
        if (ack != '0) begin tmo = 1'b0; c_ack = cyc; break; end
      end
    end
    vectors++;
    if (tmo) begin
      miscompares++;
      $display("FAIL timeout_wait: got no Ack within budget, want Ack with Err");
    end
    vectors++;
    if (ack !== 2'b01 || err !== 1'b1 || extra !== 0) begin
      miscompares++;
      $display("FAIL timeout_ack: got ack=%b err=%b extra_txen=%0d, want ack=01 err=1 extra_txen=0", ack, err, extra);
    end
    vectors++;
    if (c_ack - c_send !== 51) begin
      miscompares++;
      $display("FAIL timeout_delay: got %0d cycles from TxEn to Ack, want 51", c_ack - c_send);
    end
    req = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ack !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_idle: got busy=%b ack=%b err=%b, want 0", busy, ack, err);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    bit tmo;
    logic [7:0] e8, o8;
    logic [N-1:0] ea, oa;
    do_reset();
    wdata[31:0] = 32'h0A0B0C0D;
    push_word(0, 32'h0A0B0C0D);
    req = 2'b01;
    tmo = 1'b0;
    for (int b = 0; b < 2; b++) begin
      tmo = 1'b1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (tx_en) begin tmo = 1'b0; break; end
      end
      if (tmo) break;
      e8 = exp_bytes.pop_front();
      vectors++;
      if (tx_data !== e8) begin
        miscompares++;
        $display("FAIL rstmid_partial: got %h, want %h", tx_data, e8);
      end
    end
    if (!tmo) begin
      tmo = 1'b1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (tx_done) begin tmo = 1'b0; break; end
      end
    end
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL rstmid_wait: got no TxDone, want second TxDone"); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (grant !== '0 || tx_en !== 1'b0 || ack !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_abort: got grant=%b txen=%b ack=%b busy=%b, want 0", grant, tx_en, ack, busy);
    end
    rst = 1'b0;
    clear_queues();
    push_word(0, 32'h0A0B0C0D);
    collect_word(1'b0, ok);
    req = '0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_timeout: got stalled transfer, want complete word"); end
    while (exp_bytes.size() != 0) begin
      e8 = exp_bytes.pop_front();
      o8 = (obs_bytes.size() != 0) ? obs_bytes.pop_front() : 8'hxx;
      vectors++;
      if (o8 !== e8) begin
        miscompares++;
        $display("FAIL rstmid_byte: got %h, want %h", o8, e8);
      end
    end
    ea = exp_ack.pop_front();
    oa = (obs_ack.size() != 0) ? obs_ack.pop_front() : 'x;
    vectors++;
    if (oa !== ea) begin
      miscompares++;
      $display("FAIL rstmid_ack: got %b, want %b", oa, ea);
    end
    @(negedge clk);
  endtask

  task automatic test_req1_word();
    bit ok;
    logic [7:0] e8, o8;
    logic [N-1:0] eg, og, ea, oa;
    logic oe;
    do_reset();
    wdata[63:32] = 32'h01020304;
    push_word(1, 32'h01020304);
    req = 2'b10;
    collect_word(1'b0, ok);
    req = '0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL req1_timeout: got stalled transfer, want complete word"); end
    while (exp_bytes.size() != 0) begin
      e8 = exp_bytes.pop_front(); eg = exp_grant.pop_front();
      o8 = (obs_bytes.size() != 0) ? obs_bytes.pop_front() : 8'hxx;
      og = (obs_grant.size() != 0) ? obs_grant.pop_front() : 'x;
      vectors++;
      if (o8 !== e8 || og !== eg) begin
        miscompares++;
        $display("FAIL req1_byte: got %h grant %b, want %h grant %b", o8, og, e8, eg);
      end
    end
    ea = exp_ack.pop_front();
    oa = (obs_ack.size() != 0) ? obs_ack.pop_front() : 'x;
    oe = (obs_err.size() != 0) ? obs_err.pop_front() : 1'bx;
    vectors++;
    if (oa !== ea || oe !== 1'b0) begin
      miscompares++;
      $display("FAIL req1_ack: got ack=%b err=%b, want ack=%b err=0", oa, oe, ea);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stray_done();
    test_timeout();
    test_reset_mid_word();
    test_req1_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
